// File: rtl/psum_row_collector.sv
// Output collector for the 5-tap systolic PE row: realigns the last-PE partial
// sums with sample tags, drops warm-up results, requantizes and buffers them.
module psum_row_collector #(
  parameter int DW    = 32,
  parameter int OW    = 16,
  parameter int LAT   = 5,
  parameter int TAPS  = 5,
  parameter int SHIFT = 8,
  parameter int RELU  = 1,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          in_last,
  input  logic [DW-1:0] psum_in,
  output logic          stall,
  output logic [OW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          busy,
  output logic          overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int IW = $clog2(TAPS) + 1;
  localparam int FW = $clog2(LAT + 1);
  localparam int SW = CW + FW;

  localparam logic [IW-1:0]        LAST_WARM = IW'(TAPS - 1);
  localparam logic signed [DW-1:0] SAT_MAX   = {{(DW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [DW-1:0] SAT_MIN   = {{(DW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  logic [LAT-1:0]        tag_valid_r;
  logic [LAT-1:0]        tag_last_r;
  logic                  d_valid_s;
  logic                  d_last_s;
  logic [FW-1:0]         inflight_s;
  logic [IW-1:0]         idx_r;

  logic signed [DW-1:0]  shifted_s;
  logic signed [DW-1:0]  clamped_s;
  logic [OW-1:0]         result_s;

  logic                  push_s;
  logic                  pop_s;
  logic                  full_s;
  logic                  wr_en_s;
  logic                  drop_s;
  logic                  nonempty_s;

  logic [OW-1:0]         mem_data_r [DEPTH];
  logic                  mem_last_r [DEPTH];
  logic [AW-1:0]         wr_ptr_r;
  logic [AW-1:0]         rd_ptr_r;
  logic [CW-1:0]         count_r;
  logic                  overflow_r;

  // Tag delay line tracks which psum_in cycles carry a real sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_valid_r <= '0;
      tag_last_r  <= '0;
    end else begin
      for (int i = LAT - 1; i > 0; i--) begin
        tag_valid_r[i] <= tag_valid_r[i-1];
        tag_last_r[i]  <= tag_last_r[i-1];
      end
      tag_valid_r[0] <= in_valid;
      tag_last_r[0]  <= in_valid & in_last;
    end
  end

  assign d_valid_s = tag_valid_r[LAT-1];
  assign d_last_s  = tag_last_r[LAT-1];

  // Population count of outstanding tags, used for stall and busy.
  always_comb begin
    inflight_s = '0;
    for (int i = 0; i < LAT; i++) begin
      inflight_s = inflight_s + FW'(tag_valid_r[i]);
    end
  end

  // Warm-up counter: the first TAPS-1 tagged results of a row are discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_r <= '0;
    end else if (d_valid_s) begin
      if (d_last_s) begin
        idx_r <= '0;
      end else if (idx_r < LAST_WARM) begin
        idx_r <= idx_r + IW'(1);
      end else begin
        idx_r <= idx_r;
      end
    end else begin
      idx_r <= idx_r;
    end
  end

  // Requantize: sign-preserving shift, optional ReLU, saturate to OW bits.
  always_comb begin
    shifted_s = $signed(psum_in) >>> SHIFT;
    if ((RELU != 0) && shifted_s[DW-1]) begin
      clamped_s = '0;
    end else begin
      clamped_s = shifted_s;
    end
    if (clamped_s > SAT_MAX) begin
      result_s = SAT_MAX[OW-1:0];
    end else if (clamped_s < SAT_MIN) begin
      result_s = SAT_MIN[OW-1:0];
    end else begin
      result_s = clamped_s[OW-1:0];
    end
  end

  assign nonempty_s = (count_r != '0);
  assign full_s     = (count_r == CW'(DEPTH));
  assign push_s     = d_valid_s && (idx_r == LAST_WARM);
  assign pop_s      = nonempty_s && out_ready;
  // When full, a simultaneous pop frees the head slot that the write reuses.
  assign wr_en_s    = push_s && (!full_s || pop_s);
  assign drop_s     = push_s && full_s && !pop_s;

  // FIFO storage; cleared on reset so the idle head reads as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_data_r[i] <= '0;
        mem_last_r[i] <= 1'b0;
      end
    end else if (wr_en_s) begin
      mem_data_r[wr_ptr_r] <= result_s;
      mem_last_r[wr_ptr_r] <= d_last_s;
    end else begin
      mem_data_r[wr_ptr_r] <= mem_data_r[wr_ptr_r];
      mem_last_r[wr_ptr_r] <= mem_last_r[wr_ptr_r];
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({wr_en_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky record of any result lost to a full FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  assign out_data  = mem_data_r[rd_ptr_r];
  assign out_last  = mem_last_r[rd_ptr_r];
  assign out_valid = nonempty_s;
  assign overflow  = overflow_r;
  // Every tag in flight may still need a slot, so reserve room for all of them.
  assign stall     = (SW'(count_r) + SW'(inflight_s)) >= SW'(DEPTH);
  assign busy      = (inflight_s != '0) || nonempty_s;

  psum_row_collector_checker #(
    .OW    (OW),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_checker (
    .clk       (clk),
    .rst       (rst),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .overflow  (overflow),
    .count     (count_r)
  );

endmodule

// Protocol invariants of the collector output and FIFO occupancy.
module psum_row_collector_checker #(
  parameter int OW    = 16,
  parameter int DEPTH = 8,
  parameter int CW    = 4
) (
  input logic          clk,
  input logic          rst,
  input logic          out_valid,
  input logic          out_ready,
  input logic [OW-1:0] out_data,
  input logic          out_last,
  input logic          overflow,
  input logic [CW-1:0] count
);

  a_count_range: assert property (@(posedge clk) disable iff (rst)
    count <= CW'(DEPTH));

  a_head_hold: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_last)));

  a_overflow_sticky: assert property (@(posedge clk) disable iff (rst)
    overflow |=> overflow);

endmodule

// File: tb/tb_psum_row_collector.sv
// Scoreboard bench for psum_row_collector: one RELU=1 and one RELU=0 instance
// share stimulus; expected results are queued when samples are driven.
module tb_psum_row_collector;

  localparam int DW    = 32;
  localparam int OW    = 16;
  localparam int LAT   = 5;
  localparam int TAPS  = 5;
  localparam int SHIFT = 8;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_last;
  logic [DW-1:0] psum_in;
  logic          out_ready;

  logic          a_stall, a_out_valid, a_out_last, a_busy, a_overflow;
  logic [OW-1:0] a_out_data;
  logic          b_stall, b_out_valid, b_out_last, b_busy, b_overflow;
  logic [OW-1:0] b_out_data;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int midx = 0;
  int pops = 0;
  int first_ov = -1;
  int first_stall = -1;
  logic [DW-1:0] dl [LAT];
  logic [OW:0]   qa [$];
  logic [OW:0]   qb [$];

  psum_row_collector #(.DW(DW), .OW(OW), .LAT(LAT), .TAPS(TAPS), .SHIFT(SHIFT),
                       .RELU(1), .DEPTH(DEPTH)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .psum_in(psum_in),
    .stall(a_stall), .out_data(a_out_data), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_last(a_out_last), .busy(a_busy), .overflow(a_overflow));

  psum_row_collector #(.DW(DW), .OW(OW), .LAT(LAT), .TAPS(TAPS), .SHIFT(SHIFT),
                       .RELU(0), .DEPTH(DEPTH)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .psum_in(psum_in),
    .stall(b_stall), .out_data(b_out_data), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_last(b_out_last), .busy(b_busy), .overflow(b_overflow));

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1);
  end

  function automatic logic [OW-1:0] requant(logic [DW-1:0] v, bit relu);
    longint x, hi, lo;
    x  = longint'($signed(v));
    x  = x >>> SHIFT;
    if (relu && x < 0) x = 0;
    hi = (longint'(1) << (OW - 1)) - 1;
    lo = -hi - 1;
    if (x > hi) x = hi;
    else if (x < lo) x = lo;
    return x[OW-1:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: drive at negedge, model the PE row delay, then score any pop.
  task automatic step(input bit v, input bit last, input logic [DW-1:0] val,
                      input bit rdy, input bit obey, output bit sent);
    logic [OW:0] e;
    @(negedge clk);
    cyc++;
    if (a_stall && first_stall < 0) first_stall = cyc;
    sent      = v && !(obey && a_stall);
    in_valid  = sent;
    in_last   = sent && last;
    out_ready = rdy;
    psum_in   = dl[LAT-1];
    for (int i = LAT - 1; i > 0; i--) dl[i] = dl[i-1];
    dl[0] = sent ? val : DW'($urandom);
    if (sent) begin
      if (midx < TAPS - 1) midx++;
      else begin
        qa.push_back({last, requant(val, 1'b1)});
        qb.push_back({last, requant(val, 1'b0)});
      end
      if (last) midx = 0;
    end
    #1;
    if (a_out_valid && first_ov < 0) first_ov = cyc;
    if (a_out_valid && out_ready) begin
      pops++;
      if (qa.size() == 0) check("a_extra_output", 32'(qa.size()), 32'd1);
      else begin
        e = qa.pop_front();
        check("a_out", {15'd0, a_out_last, a_out_data}, {15'd0, e});
      end
    end
    if (b_out_valid && out_ready) begin
      if (qb.size() == 0) check("b_extra_output", 32'(qb.size()), 32'd1);
      else begin
        e = qb.pop_front();
        check("b_out", {15'd0, b_out_last, b_out_data}, {15'd0, e});
      end
    end
  endtask

  task automatic idle(input int n, input bit rdy);
    bit s;
    repeat (n) step(1'b0, 1'b0, '0, rdy, 1'b0, s);
  endtask

  task automatic ramp_row(input int n, input bit rdy);
    bit s;
    for (int k = 0; k < n; k++) step(1'b1, k == n - 1, DW'(k * 256), rdy, 1'b0, s);
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while ((qa.size() != 0 || qb.size() != 0 || a_busy) && k < 300) begin
      idle(1, 1'b1);
      k++;
    end
    check({tag, "_left"}, 32'(qa.size() + qb.size()), 32'd0);
    check({tag, "_busy"}, {31'd0, a_busy}, 32'd0);
  endtask

  task automatic clear_model();
    qa.delete();
    qb.delete();
    midx = 0;
    for (int i = 0; i < LAT; i++) dl[i] = '0;
  endtask

  task automatic first_scenario(input string tag);
    int c0;
    first_ov = -1;
    pops = 0;
    c0 = cyc + 1;
    ramp_row(8, 1'b1);
    drain(tag);
    check({tag, "_latency"}, 32'(first_ov - c0), 32'd10);
    check({tag, "_count"}, 32'(pops), 32'd4);
  endtask

  logic [DW-1:0] arith_vals [8];
  bit s;
  int sent_n;
  int c0;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; psum_in = '0; out_ready = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
    check("rst_out_data",  {16'd0, a_out_data}, 32'd0);
    check("rst_out_last",  {31'd0, a_out_last}, 32'd0);
    check("rst_overflow",  {31'd0, a_overflow}, 32'd0);
    check("rst_busy",      {31'd0, a_busy}, 32'd0);
    check("rst_stall",     {31'd0, a_stall}, 32'd0);
    rst = 1'b0;

    // Ramp row: four results 4..7, last flag on the final one.
    first_scenario("ramp");

    // Requantization corner values after four warm-up samples.
    arith_vals = '{32'h11, 32'h22, 32'h33, 32'h44,
                   32'h0001_2345, 32'hFFFF_FF00, 32'h7FFF_FFFF, 32'h8000_0000};
    for (int k = 0; k < 8; k++) step(1'b1, k == 7, arith_vals[k], 1'b1, 1'b0, s);
    drain("arith");

    // Short row produces nothing; the following 6-sample row yields two.
    pops = 0;
    ramp_row(3, 1'b1);
    idle(LAT + 2, 1'b1);
    check("short_none", 32'(pops), 32'd0);
    ramp_row(6, 1'b1);
    drain("short");
    check("short_next_count", 32'(pops), 32'd2);

    // Backpressure with an obedient feeder: stall at occupancy 8, no drops.
    first_stall = -1;
    sent_n = 0;
    c0 = cyc + 1;
    for (int it = 0; it < 40 && sent_n < 14; it++) begin
      step(1'b1, sent_n == 13, DW'($urandom), it >= 25, 1'b1, s);
      if (s) sent_n++;
      if (it == 20) check("bp_stall_held", {31'd0, a_stall}, 32'd1);
    end
    check("bp_sent", 32'(sent_n), 32'd14);
    check("bp_stall_cycle", 32'(first_stall - c0), 32'd12);
    drain("bp");
    check("bp_overflow", {31'd0, a_overflow}, 32'd0);

    // Feeder ignores stall: 9 results, only 8 fit, the last one is lost.
    for (int k = 0; k < 13; k++) step(1'b1, k == 12, DW'($urandom), 1'b0, 1'b0, s);
    idle(LAT + 3, 1'b0);
    check("ovf_set", {31'd0, a_overflow}, 32'd1);
    check("ovf_set_b", {31'd0, b_overflow}, 32'd1);
    void'(qa.pop_back());
    void'(qb.pop_back());
    drain("ovf");
    check("ovf_sticky", {31'd0, a_overflow}, 32'd1);

    // Reset with three buffered results, then a clean ramp row.
    ramp_row(7, 1'b0);
    idle(LAT + 2, 1'b0);
    check("mid_valid_before", {31'd0, a_out_valid}, 32'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_out_valid", {31'd0, a_out_valid}, 32'd0);
    check("mid_busy", {31'd0, a_busy}, 32'd0);
    check("mid_overflow", {31'd0, a_overflow}, 32'd0);
    clear_model();
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    first_scenario("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
